spare_signal_generator: RTL

Sequential enumerator that produces every legal spare-allocation candidate: DSSS (8 bits, exactly 4 set) paired with RLSS (4 bits, exactly 2 set), one candidate per accepted handshake. It sits upstream of the signal validity checker and drives its DSSS/RLSS inputs. Every emitted candidate passes the checker's popcount test by construction. A skip input lets the downstream repair-analysis logic prune the remaining RLSS candidates of the current DSSS.

---
 rtl/spare_signal_generator_if.sv | 25 ++
 rtl/spare_signal_generator.sv | 104 ++++++++++
 2 files changed

// File: rtl/spare_signal_generator_if.sv
// Candidate stream between the spare-allocation enumerator and its consumer.
// The master side is the generator; the slave side is the checker/repair logic.
interface spare_signal_generator_if;
  logic       start;
  logic       out_ready;
  logic       skip_dsss;
  logic       out_valid;
  logic [7:0] dsss;
  logic [3:0] rlss;
  logic [8:0] cand_idx;
  logic       last;
  logic [8:0] emitted_cnt;
  logic       busy;
  logic       done;

  modport master (
    input  start, out_ready, skip_dsss,
    output out_valid, dsss, rlss, cand_idx, last, emitted_cnt, busy, done
  );

  modport slave (
    output start, out_ready, skip_dsss,
    input  out_valid, dsss, rlss, cand_idx, last, emitted_cnt, busy, done
  );
endinterface

// File: rtl/spare_signal_generator.sv
// Enumerates every DSSS (8b, four ones) x RLSS (4b, two ones) spare candidate,
// one per handshake, with optional pruning of the remaining RLSS values.
module spare_signal_generator (
  input logic clk,
  input logic rst,
  spare_signal_generator_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [6:0] dsss_rank;
  logic [2:0] rlss_rank;
  logic [7:0] dsss_next;
  logic [3:0] rlss_next;

  function automatic logic [3:0] trailing_zeros(input logic [8:0] x);
    trailing_zeros = 4'd9;
    for (int i = 8; i >= 0; i--) begin
      if (x[i]) trailing_zeros = 4'(i);
    end
  endfunction

  // Gosper's step: ripple the lowest run of ones up, then refill the bottom;
  // the divide by the lowest set bit becomes a shift by its position.
  function automatic logic [7:0] next_comb8(input logic [7:0] x);
    logic [8:0] xe, low, ripple, ones;
    xe     = {1'b0, x};
    low    = xe & (~xe + 9'd1);
    ripple = xe + low;
    ones   = ((ripple ^ xe) >> 2) >> trailing_zeros(xe);
    next_comb8 = ripple[7:0] | ones[7:0];
  endfunction

  function automatic logic [3:0] next_comb4(input logic [3:0] x);
    logic [4:0] xe, low, ripple, ones;
    xe     = {1'b0, x};
    low    = xe & (~xe + 5'd1);
    ripple = xe + low;
    ones   = ((ripple ^ xe) >> 2) >> trailing_zeros({4'd0, xe});
    next_comb4 = ripple[3:0] | ones[3:0];
  endfunction

  assign dsss_next = next_comb8(bus.dsss);
  assign rlss_next = next_comb4(bus.rlss);

  // Index is derived from the ranks so it can never drift from them.
  assign bus.cand_idx = {dsss_rank, 2'b00} + {1'b0, dsss_rank, 1'b0} + {6'd0, rlss_rank};
  assign bus.last     = bus.out_valid && (bus.dsss == 8'hF0) && (bus.rlss == 4'hC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.out_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.dsss        <= 8'd0;
      bus.rlss        <= 4'd0;
      bus.emitted_cnt <= 9'd0;
      dsss_rank       <= 7'd0;
      rlss_rank       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state           <= RUN;
            bus.out_valid   <= 1'b1;
            bus.busy        <= 1'b1;
            bus.dsss        <= 8'h0F;
            bus.rlss        <= 4'h3;
            bus.emitted_cnt <= 9'd0;
            dsss_rank       <= 7'd0;
            rlss_rank       <= 3'd0;
          end
        end
        RUN: begin
          // out_valid is always high here, so out_ready alone marks a handshake
          if (bus.out_ready) begin
            bus.emitted_cnt <= bus.emitted_cnt + 9'd1;
            if (bus.dsss == 8'hF0 && (bus.rlss == 4'hC || bus.skip_dsss)) begin
              state         <= DONE;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end else if (bus.skip_dsss || bus.rlss == 4'hC) begin
              bus.dsss  <= dsss_next;
              dsss_rank <= dsss_rank + 7'd1;
              bus.rlss  <= 4'h3;
              rlss_rank <= 3'd0;
            end else begin
              bus.rlss  <= rlss_next;
              rlss_rank <= rlss_rank + 3'd1;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
